// File: rtl/atm_ctrl_param.sv
// atm_ctrl_param: parametrised ATM session controller with PIN attempt lock-out,
// inactivity timeout and overflow-checked deposit/withdraw against an internal balance.
module atm_ctrl_param #(
  parameter int PIN_DIGITS = 4,
  parameter int MAX_ATTEMPTS = 3,
  parameter int BAL_W = 64,
  parameter logic [BAL_W-1:0] INIT_BALANCE = '0,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    TARJETA_RECIBIDA,
  input  logic [4*PIN_DIGITS-1:0] PIN,
  input  logic [3:0]              DIGITO,
  input  logic                    DIGITO_STB,
  input  logic                    TIPO_TRANS,
  input  logic                    TIPO_STB,
  input  logic [31:0]             MONTO,
  input  logic                    MONTO_STB,
  output logic                    BALANCE_ACTUALIZADO,
  output logic                    ENTREGAR_DINERO,
  output logic                    FONDOS_INSUFICIENTES,
  output logic                    DEPOSITO_RECHAZADO,
  output logic                    PIN_INCORRECTO,
  output logic                    ADVERTENCIA,
  output logic                    Bloqueo,
  output logic                    TIEMPO_AGOTADO,
  output logic [BAL_W-1:0]        BALANCE
);
  localparam int PW = 4 * PIN_DIGITS;
  localparam int EW = ((BAL_W > 32) ? BAL_W : 32) + 1;
  localparam logic [3:0] LAST_DIG = 4'(PIN_DIGITS - 1);
  localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);
  localparam logic [31:0] T_LIM = 32'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, PIN_ENTRY, WAIT_TYPE, WAIT_MONTO, DONE, BLOCKED} state_t;
  state_t state;
  logic [PW-1:0] entry, pin_next;
  logic [3:0] ndig, attempts, att_next;
  logic [31:0] timer;
  logic tipo, dig_p, tipo_p, monto_p, dig_e, tipo_e, monto_e, active, tmo_hit, ovf;
  logic [EW-1:0] bal_x, amt_x, sum_x;
  assign dig_e = DIGITO_STB & ~dig_p;
  assign tipo_e = TIPO_STB & ~tipo_p;
  assign monto_e = MONTO_STB & ~monto_p;
  assign pin_next = PW'({entry, DIGITO});
  assign att_next = attempts + 4'd1;
  assign active = (state == PIN_ENTRY) || (state == WAIT_TYPE) || (state == WAIT_MONTO);
  assign tmo_hit = (TIMEOUT_CYC != 0) && (timer == T_LIM);
  // Balance and amount widened past both widths so the carry out of BAL_W is visible
  assign bal_x = EW'(BALANCE);
  assign amt_x = EW'(MONTO);
  assign sum_x = bal_x + amt_x;
  assign ovf = |(sum_x >> BAL_W);
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      BALANCE <= INIT_BALANCE;
      entry <= '0;
      ndig <= '0;
      attempts <= '0;
      timer <= '0;
      tipo <= 1'b0;
      dig_p <= 1'b0;
      tipo_p <= 1'b0;
      monto_p <= 1'b0;
      BALANCE_ACTUALIZADO <= 1'b0;
      ENTREGAR_DINERO <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      DEPOSITO_RECHAZADO <= 1'b0;
      PIN_INCORRECTO <= 1'b0;
      ADVERTENCIA <= 1'b0;
      Bloqueo <= 1'b0;
      TIEMPO_AGOTADO <= 1'b0;
    end else begin
      dig_p <= DIGITO_STB;
      tipo_p <= TIPO_STB;
      monto_p <= MONTO_STB;
      BALANCE_ACTUALIZADO <= 1'b0;
      ENTREGAR_DINERO <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      DEPOSITO_RECHAZADO <= 1'b0;
      PIN_INCORRECTO <= 1'b0;
      TIEMPO_AGOTADO <= 1'b0;
      timer <= active ? timer + 32'd1 : '0;
      if (active && !TARJETA_RECIBIDA) begin
        state <= IDLE;
      end else if (state == IDLE && TARJETA_RECIBIDA) begin
        state <= PIN_ENTRY;
        ndig <= '0;
        entry <= '0;
        timer <= '0;
      end else if (state == PIN_ENTRY && dig_e) begin
        timer <= '0;
        if (ndig != LAST_DIG) begin
          entry <= pin_next;
          ndig <= ndig + 4'd1;
        end else begin
          ndig <= '0;
          entry <= '0;
          if (pin_next == PIN) begin
            state <= WAIT_TYPE;
            attempts <= '0;
            ADVERTENCIA <= 1'b0;
          end else begin
            PIN_INCORRECTO <= 1'b1;
            attempts <= att_next;
            if (att_next == MAX_A) begin
              state <= BLOCKED;
              Bloqueo <= 1'b1;
              ADVERTENCIA <= 1'b0;
            end else if (att_next == MAX_A - 4'd1) begin
              ADVERTENCIA <= 1'b1;
            end
          end
        end
      end else if (state == WAIT_TYPE && tipo_e) begin
        tipo <= TIPO_TRANS;
        state <= WAIT_MONTO;
        timer <= '0;
      end else if (state == WAIT_MONTO && monto_e) begin
        state <= DONE;
        timer <= '0;
        if (!tipo) begin
          if (ovf) DEPOSITO_RECHAZADO <= 1'b1;
          else begin
            BALANCE <= sum_x[BAL_W-1:0];
            BALANCE_ACTUALIZADO <= 1'b1;
          end
        end else if (amt_x > bal_x) begin
          FONDOS_INSUFICIENTES <= 1'b1;
        end else begin
          BALANCE <= BAL_W'(bal_x - amt_x);
          BALANCE_ACTUALIZADO <= 1'b1;
          ENTREGAR_DINERO <= 1'b1;
        end
      end else if (active && tmo_hit) begin
        TIEMPO_AGOTADO <= 1'b1;
        state <= DONE;
        timer <= '0;
      end else if (state == DONE && !TARJETA_RECIBIDA) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_atm_ctrl_param.sv
// tb_atm_ctrl_param: scoreboard bench for atm_ctrl_param; a 64-bit instance carries the
// main sessions and a 16-bit instance preloaded near full checks deposit overflow.
module tb_atm_ctrl_param;
  typedef struct packed {logic [5:0] p; logic [63:0] bal;} evt_t;
  localparam logic [5:0] UPD = 6'b100000, ENT = 6'b010000, FND = 6'b001000;
  localparam logic [5:0] REJ = 6'b000100, PINC = 6'b000010, TMO = 6'b000001;
  localparam int TO = 20;
  logic Clk = 0, Reset = 0, TARJETA_RECIBIDA = 0, DIGITO_STB = 0;
  logic TIPO_TRANS = 0, TIPO_STB = 0, MONTO_STB = 0;
  logic [15:0] PIN = 16'h5916;
  logic [3:0] DIGITO = 0;
  logic [31:0] MONTO = 0;
  logic upd0, ent0, fnd0, rej0, pinc0, adv0, blk0, tmo0;
  logic upd1, ent1, fnd1, rej1, pinc1, adv1, blk1, tmo1;
  logic [63:0] bal0;
  logic [15:0] bal1;
  int tests = 0, fails = 0;
  evt_t exp_q[$], obs_q[$];
  always #5 Clk = ~Clk;
  atm_ctrl_param #(.TIMEOUT_CYC(TO)) dut0 (
    .Clk(Clk), .Reset(Reset), .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .PIN(PIN),
    .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .TIPO_TRANS(TIPO_TRANS), .TIPO_STB(TIPO_STB),
    .MONTO(MONTO), .MONTO_STB(MONTO_STB), .BALANCE_ACTUALIZADO(upd0), .ENTREGAR_DINERO(ent0),
    .FONDOS_INSUFICIENTES(fnd0), .DEPOSITO_RECHAZADO(rej0), .PIN_INCORRECTO(pinc0),
    .ADVERTENCIA(adv0), .Bloqueo(blk0), .TIEMPO_AGOTADO(tmo0), .BALANCE(bal0));
  atm_ctrl_param #(.BAL_W(16), .INIT_BALANCE(16'd65000), .TIMEOUT_CYC(TO)) dut1 (
    .Clk(Clk), .Reset(Reset), .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .PIN(PIN),
    .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .TIPO_TRANS(TIPO_TRANS), .TIPO_STB(TIPO_STB),
    .MONTO(MONTO), .MONTO_STB(MONTO_STB), .BALANCE_ACTUALIZADO(upd1), .ENTREGAR_DINERO(ent1),
    .FONDOS_INSUFICIENTES(fnd1), .DEPOSITO_RECHAZADO(rej1), .PIN_INCORRECTO(pinc1),
    .ADVERTENCIA(adv1), .Bloqueo(blk1), .TIEMPO_AGOTADO(tmo1), .BALANCE(bal1));
  always @(posedge Clk) begin
    #2;
    if (Reset && {upd0, ent0, fnd0, rej0, pinc0, tmo0} != 6'd0)
      obs_q.push_back({upd0, ent0, fnd0, rej0, pinc0, tmo0, bal0});
  end
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask
  task automatic card(input logic v);
    TARJETA_RECIBIDA = v;
    tick(1);
  endtask
  task automatic digit(input logic [3:0] d, input int hold);
    DIGITO = d;
    DIGITO_STB = 1;
    tick(hold);
    DIGITO_STB = 0;
    tick(1);
  endtask
  task automatic enter_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) digit(p[4*i+:4], 1);
  endtask
  task automatic tipo(input logic t);
    TIPO_TRANS = t;
    TIPO_STB = 1;
    tick(1);
    TIPO_STB = 0;
    tick(1);
  endtask
  task automatic amount(input logic [31:0] m);
    MONTO = m;
    MONTO_STB = 1;
    tick(1);
    MONTO_STB = 0;
    tick(1);
  endtask
  task automatic do_reset;
    {TARJETA_RECIBIDA, DIGITO_STB, TIPO_STB, MONTO_STB} = '0;
    @(negedge Clk);
    Reset = 0;
    tick(2);
    Reset = 1;
    tick(1);
  endtask
  task automatic get_obs(output evt_t o, output int w);
    w = 0;
    while (obs_q.size() == 0 && w < 200) begin
      tick(1);
      w++;
    end
    if (obs_q.size() != 0) o = obs_q.pop_front();
    else o = '1;
  endtask
  task automatic test_reset;
    do_reset;
    tests++;
    if (bal0 !== 64'd0) begin fails++; $display("FAIL reset_bal: got %0d want 0", bal0); end
    tests++;
    if ({upd0, ent0, fnd0, rej0, pinc0, adv0, blk0, tmo0} !== 8'd0) begin
      fails++; $display("FAIL reset_outs: got %b want 0", {upd0, ent0, fnd0, rej0, pinc0, adv0, blk0, tmo0});
    end
    tests++;
    if (bal1 !== 16'd65000) begin fails++; $display("FAIL reset_init_bal: got %0d want 65000", bal1); end
  endtask
  task automatic test_deposit;
    evt_t o, e;
    int w;
    card(1);
    enter_pin(16'h5916);
    tipo(0);
    exp_q.push_back({UPD, 64'd10000});
    amount(32'd10000);
    get_obs(o, w);
    e = exp_q.pop_front();
    tests++;
    if (o !== e) begin fails++; $display("FAIL deposit: got p=%b bal=%0d want p=%b bal=%0d", o.p, o.bal, e.p, e.bal); end
    card(0);
    tick(1);
  endtask
  task automatic test_withdraw;
    evt_t o, e;
    int w;
    card(1);
    enter_pin(16'h5916);
    tipo(1);
    exp_q.push_back({UPD | ENT, 64'd1000});
    amount(32'd9000);
    get_obs(o, w);
    e = exp_q.pop_front();
    tests++;
    if (o !== e) begin fails++; $display("FAIL withdraw: got p=%b bal=%0d want p=%b bal=%0d", o.p, o.bal, e.p, e.bal); end
    card(0);
    tick(1);
    card(1);
    enter_pin(16'h5916);
    tipo(1);
    exp_q.push_back({FND, 64'd1000});
    amount(32'd2000);
    get_obs(o, w);
    e = exp_q.pop_front();
    tests++;
    if (o !== e) begin fails++; $display("FAIL insufficient: got p=%b bal=%0d want p=%b bal=%0d", o.p, o.bal, e.p, e.bal); end
    card(0);
    tick(1);
  endtask
  task automatic test_lockout;
    evt_t o, e;
    int w;
    logic [15:0] bad [3] = '{16'h4916, 16'h5917, 16'h5316};
    card(1);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({PINC, 64'd1000});
      enter_pin(bad[k]);
      get_obs(o, w);
      e = exp_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL wrong_pin%0d: got p=%b bal=%0d want p=%b bal=%0d", k, o.p, o.bal, e.p, e.bal); end
      tests++;
      if (adv0 !== (k == 1)) begin fails++; $display("FAIL advert%0d: got %b want %b", k, adv0, k == 1); end
    end
    tests++;
    if (blk0 !== 1'b1) begin fails++; $display("FAIL blocked: got %b want 1", blk0); end
    enter_pin(16'h5916);
    tipo(0);
    amount(32'd5);
    card(0);
    tick(3);
    tests++;
    if (blk0 !== 1'b1 || obs_q.size() != 0) begin
      fails++; $display("FAIL blocked_hold: got blk=%b events=%0d want blk=1 events=0", blk0, obs_q.size());
    end
    do_reset;
    tests++;
    if (blk0 !== 1'b0 || bal0 !== 64'd0) begin fails++; $display("FAIL unblock: got blk=%b bal=%0d want blk=0 bal=0", blk0, bal0); end
  endtask
  task automatic test_adv_clear;
    evt_t o, e;
    int w;
    card(1);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({PINC, 64'd0});
      enter_pin(16'h1234);
      get_obs(o, w);
      e = exp_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL adv_wrong%0d: got p=%b bal=%0d want p=%b bal=%0d", k, o.p, o.bal, e.p, e.bal); end
    end
    tests++;
    if (adv0 !== 1'b1) begin fails++; $display("FAIL adv_set: got %b want 1", adv0); end
    enter_pin(16'h5916);
    tests++;
    if (adv0 !== 1'b0) begin fails++; $display("FAIL adv_clear: got %b want 0", adv0); end
    tipo(0);
    exp_q.push_back({UPD, 64'd8000});
    amount(32'd8000);
    get_obs(o, w);
    e = exp_q.pop_front();
    tests++;
    if (o !== e) begin fails++; $display("FAIL adv_deposit: got p=%b bal=%0d want p=%b bal=%0d", o.p, o.bal, e.p, e.bal); end
    card(0);
    tick(1);
    card(1);
    exp_q.push_back({PINC, 64'd8000});
    enter_pin(16'h0000);
    get_obs(o, w);
    e = exp_q.pop_front();
    tests++;
    if (o !== e) begin fails++; $display("FAIL single_wrong: got p=%b bal=%0d want p=%b bal=%0d", o.p, o.bal, e.p, e.bal); end
    tests++;
    if (adv0 !== 1'b0) begin fails++; $display("FAIL counter_cleared: got adv=%b want 0", adv0); end
    card(0);
    tick(1);
  endtask
  task automatic test_timeout;
    evt_t o, e;
    int w;
    card(1);
    digit(4'h5, 1);
    digit(4'h9, 1);
    exp_q.push_back({TMO, 64'd8000});
    get_obs(o, w);
    e = exp_q.pop_front();
    tests++;
    if (o !== e) begin fails++; $display("FAIL timeout: got p=%b bal=%0d want p=%b bal=%0d", o.p, o.bal, e.p, e.bal); end
    tests++;
    if (w < TO - 5 || w > TO + 2) begin fails++; $display("FAIL timeout_delay: got %0d cycles want about %0d", w, TO - 1); end
    card(0);
    tick(1);
    card(1);
    enter_pin(16'h5916);
    tipo(0);
    exp_q.push_back({UPD, 64'd8000});
    amount(32'd0);
    get_obs(o, w);
    e = exp_q.pop_front();
    tests++;
    if (o !== e) begin fails++; $display("FAIL resume_zero: got p=%b bal=%0d want p=%b bal=%0d", o.p, o.bal, e.p, e.bal); end
    card(0);
    tick(1);
  endtask
  task automatic test_overflow_hold;
    evt_t o, e;
    int w;
    do_reset;
    card(1);
    digit(4'h5, 3);
    digit(4'h9, 1);
    digit(4'h1, 1);
    digit(4'h6, 1);
    tipo(0);
    exp_q.push_back({UPD, 64'd1000});
    MONTO = 32'd1000;
    MONTO_STB = 1;
    tick(1);
    tests++;
    if (rej1 !== 1'b1 || upd1 !== 1'b0 || bal1 !== 16'd65000) begin
      fails++; $display("FAIL overflow: got rej=%b upd=%b bal=%0d want rej=1 upd=0 bal=65000", rej1, upd1, bal1);
    end
    MONTO_STB = 0;
    tick(1);
    get_obs(o, w);
    e = exp_q.pop_front();
    tests++;
    if (o !== e) begin fails++; $display("FAIL held_strobe: got p=%b bal=%0d want p=%b bal=%0d", o.p, o.bal, e.p, e.bal); end
    card(0);
    tick(2);
  endtask
  initial begin
    test_reset;
    test_deposit;
    test_withdraw;
    test_lockout;
    test_adv_clear;
    test_timeout;
    test_overflow_hold;
    tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      fails++; $display("FAIL leftover: got exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/atm_ctrl_param.md
Name: atm_ctrl_param

Overview:
- Parametrised next-generation ATM transaction controller: PIN entry, attempt limiting with lock-out, deposit/withdraw against an internal balance.
- Adds configurable PIN length, attempt count and balance width, an inactivity timeout, and deposit-overflow rejection.
- Driven by the card reader, keypad and amount-entry front end; its outputs drive the dispenser and operator-status logic.

Parameters:
- PIN_DIGITS, 4, number of BCD digits in the PIN (1..8).
- MAX_ATTEMPTS, 3, wrong-PIN tries before lock-out (2..15).
- BAL_W, 64, balance register width in bits; MONTO is 32 bits and is zero-extended.
- INIT_BALANCE, 0, balance value loaded at reset.
- TIMEOUT_CYC, 64, idle cycles allowed while a card is inserted before the session aborts; 0 disables the timeout.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- TARJETA_RECIBIDA  in  1  level: card present.
- PIN  in  4*PIN_DIGITS  expected PIN in BCD, most-significant digit first; valid while the card is present.
- DIGITO  in  4  keypad digit.
- DIGITO_STB  in  1  digit strobe.
- TIPO_TRANS  in  1  transaction type: 0 = deposit, 1 = withdraw.
- TIPO_STB  in  1  transaction-type strobe.
- MONTO  in  32  amount.
- MONTO_STB  in  1  amount strobe.
- BALANCE_ACTUALIZADO  out  1  one-cycle pulse: balance changed.
- ENTREGAR_DINERO  out  1  one-cycle pulse: dispense cash.
- FONDOS_INSUFICIENTES  out  1  one-cycle pulse: withdrawal refused.
- DEPOSITO_RECHAZADO  out  1  one-cycle pulse: deposit would overflow.
- PIN_INCORRECTO  out  1  one-cycle pulse: wrong PIN.
- ADVERTENCIA  out  1  level: one attempt left.
- Bloqueo  out  1  level: locked out.
- TIEMPO_AGOTADO  out  1  one-cycle pulse: session timed out.
- BALANCE  out  BAL_W  current balance.

Behaviour:
- Reset (async, Reset=0):
  - State IDLE; BALANCE=INIT_BALANCE; attempt counter, digit counter and timer cleared.
  - All outputs 0.
  - Reset is honoured in every state, including BLOCKED and mid-transaction; it is the only exit from BLOCKED.
- Strobes:
  - All three strobes are rising-edge detected internally (registered previous value, reset 0).
  - A strobe held high for N cycles counts once.
  - A strobe arriving in a state that does not expect it is ignored.
- States: IDLE, PIN_ENTRY, WAIT_TYPE, WAIT_MONTO, DONE, BLOCKED.
- IDLE: TARJETA_RECIBIDA=1 -> PIN_ENTRY; digit counter=0; entry shift register cleared.
- PIN_ENTRY:
  - Each DIGITO_STB edge shifts DIGITO into the low nibble.
  - On the edge of digit number PIN_DIGITS, the register-plus-new-digit is compared with PIN in the same cycle.
  - Match -> WAIT_TYPE next cycle; attempt counter=0; ADVERTENCIA cleared.
  - Mismatch -> PIN_INCORRECTO pulses the next cycle; attempt counter increments; digit counter=0; remain in PIN_ENTRY.
  - Counter reaches MAX_ATTEMPTS-1 -> ADVERTENCIA=1 (level).
  - Counter reaches MAX_ATTEMPTS -> BLOCKED; Bloqueo=1; ADVERTENCIA=0.
- Attempt counter persistence: the counter is not cleared by card removal. Only a correct PIN or Reset clears it, so removing the card does not bypass lock-out.
- WAIT_TYPE: TIPO_STB edge latches TIPO_TRANS -> WAIT_MONTO.
- WAIT_MONTO: MONTO_STB edge latches MONTO; the result is registered next cycle:
  - Deposit, BALANCE + MONTO fits in BAL_W -> BALANCE updated; BALANCE_ACTUALIZADO pulse.
  - Deposit, overflow -> DEPOSITO_RECHAZADO pulse; BALANCE unchanged.
  - Withdraw, MONTO <= BALANCE -> BALANCE -= MONTO; BALANCE_ACTUALIZADO and ENTREGAR_DINERO pulse in the same cycle.
  - Withdraw, MONTO > BALANCE -> FONDOS_INSUFICIENTES pulse; BALANCE unchanged.
  - MONTO=0 is legal: update pulses fire, value unchanged.
  - In every case -> DONE.
- DONE: waits for TARJETA_RECIBIDA=0 -> IDLE.
- Card removal in PIN_ENTRY, WAIT_TYPE or WAIT_MONTO -> IDLE next cycle; any partially entered PIN is discarded.
- BLOCKED:
  - All strobes ignored; card removal ignored.
  - Bloqueo held until Reset.
- Timeout:
  - Timer runs in PIN_ENTRY, WAIT_TYPE and WAIT_MONTO; it clears on any accepted strobe edge and on state entry.
  - Timer reaches TIMEOUT_CYC -> TIEMPO_AGOTADO pulse and -> DONE; the attempt counter is not changed.
  - The timer is disabled when TIMEOUT_CYC=0.
- Simultaneous events:
  - Card removal in the same cycle as a strobe edge: removal wins and the strobe is dropped.
  - A strobe edge on the timeout cycle clears the timer, and the strobe wins.

Test Plan:
- Reset, card in, PIN=16'h5916, digits 5,9,1,6, TIPO=0, MONTO=10000 -> BALANCE_ACTUALIZADO pulse, BALANCE=10000; card out -> IDLE.
- Same PIN, TIPO=1, MONTO=9000 -> ENTREGAR_DINERO and BALANCE_ACTUALIZADO pulse, BALANCE=1000; repeat with MONTO=2000 -> FONDOS_INSUFICIENTES only, BALANCE=1000.
- Digits 4916, then 5917 -> PIN_INCORRECTO twice, ADVERTENCIA=1 after the second; then 5316 -> Bloqueo=1; correct 5916 plus TIPO_STB ignored; Reset low -> Bloqueo=0, BALANCE=INIT_BALANCE.
- Two wrong PINs, then 5916, deposit 8000 -> ADVERTENCIA clears on the match; BALANCE += 8000; attempt counter=0 (a subsequent single wrong PIN does not raise ADVERTENCIA).
- Card in, two digits, then no activity for TIMEOUT_CYC cycles -> TIEMPO_AGOTADO pulse, state DONE; card out/in resumes PIN_ENTRY with the digit counter 0.
- BAL_W=16, BALANCE=65000, deposit 1000 -> DEPOSITO_RECHAZADO; BALANCE=65000; DIGITO_STB held high for 3 cycles counts as one digit.
